feature_mem_reader: RTL and testbench
=====================================

// Module: feature_mem_reader
// PURPOSE
//  Read-side sequencer for the 4-bank feature memory. It waits for write_done, then walks
//  word addresses 0..NUM_WORDS-1 and drives read_address/re. It captures the 4-lane read
//  data (out0..out3) and streams it to the HD encoder as one 4-feature beat per word, using
//  a valid/ready handshake. A small FIFO absorbs encoder backpressure and hides the memory
//  read latency.
// PARAMETERS
//  FEATURE_WIDTH  32   width of one feature / one bank word
//  ADDR_WIDTH     8    bank address width
//  NUM_FEATURES   512  features per sample; NUM_WORDS = NUM_FEATURES/4 (default 128)
//  FIFO_DEPTH     4    output FIFO entries; power of 2, >=4
// PORTS
//  clk           in   1             clock, rising edge
//  reset         in   1             synchronous, active-high
//  write_done    in   1             feature memory fully written
//  start         in   1             one-cycle pulse: begin streaming one sample
//  read_address  out  ADDR_WIDTH    word address to feature memory
//  re            out  1             read strobe; read_address valid this cycle
//  mem_out0..3   in   FEATURE_WIDTH bank data; valid the cycle after re
//  f_valid       out  1             beat valid
//  f_ready       in   1             encoder accepts beat
//  f0..f3        out  FEATURE_WIDTH features 4k..4k+3 of word k
//  f_index       out  ADDR_WIDTH    word index k of current beat
//  f_last        out  1             current beat is word NUM_WORDS-1
//  busy          out  1             state==STREAM
//  done          out  1             sample fully delivered; sticky
// BEHAVIOUR
//  Reset: state=IDLE; counters, inflight and FIFO cleared.
//   Outputs: read_address=0, re=0, f_valid=0, f_last=0, f_index=0, busy=0, done=0,
//   f0..f3=0.
//  FSM: IDLE -> STREAM on start & write_done (sampled at edge).
//   STREAM -> DONE on handshake (f_valid & f_ready & f_last).
//   DONE -> STREAM on start & write_done (done clears same edge).
//   start with write_done=0 is ignored. start while in STREAM is ignored.
//  Issue rule, in STREAM: re=1 iff issue_cnt<NUM_WORDS and fifo_count+inflight<FIFO_DEPTH.
//   read_address=issue_cnt (registered counter); issue_cnt increments on each re.
//   re is combinational from registered state; read_address is 0 outside STREAM.
//  Memory timing: mem_out* valid in cycle C+1 for re in cycle C.
//   The 4 lanes and the word index are pushed into the FIFO at the end of C+1.
//   inflight counts issues not yet pushed (0..2).
//  Latency: start edge E -> re at cycle E+1 -> first f_valid at E+3.
//   With f_ready held high: one beat/cycle, no bubbles. Last beat at E+2+NUM_WORDS.
//  Output: f0..f3/f_index/f_last come from the FIFO head. f_valid = fifo non-empty.
//   Beat is held stable while f_valid & !f_ready.
//   Simultaneous push+pop on a full FIFO cannot occur (credit rule); push+pop otherwise
//   legal, count unchanged.
//  Word counter wrap: issue_cnt is ADDR_WIDTH+1 bits, so NUM_WORDS=2^ADDR_WIDTH does not
//   alias 0.
//  write_done falling while in STREAM = abort:
//   next edge -> IDLE; FIFO, inflight and counters flushed; done stays 0.
//   Data returning from an already-issued read is discarded.
//  reset mid-STREAM: same flush, all outputs to reset values next cycle.
//  done=1 from the edge after the last handshake until the next accepted start or reset.
// TESTING (memory model: registered read, mem_outN = 4*addr+N)
//  1 reset; write_done=1; start pulse; f_ready=1.
//    -> re at +1 with addr 0; f_valid at +3 with f0..f3=0,1,2,3, f_index=0.
//    -> 128 consecutive beats; beat 127 = 508..511 with f_last=1; done=1 next cycle.
//  2 start with write_done=0.
//    -> stays IDLE: re=0, busy=0 for 10 cycles.
//    Then raise write_done and pulse start -> stream begins normally.
//  3 f_ready toggling 1010.., then held 0 for 20 cycles.
//    -> re stops once fifo_count+inflight=4; beat stable while stalled.
//    -> no loss or duplication; f_index sequence 0..127 exact.
//  4 drop write_done at beat 40.
//    -> IDLE next edge, f_valid=0, done=0.
//    Restart -> first beat f_index=0, f0=0.
//  5 reset asserted at beat 70 with FIFO full -> all outputs 0 next cycle; restart clean.
//  6 start pulsed during STREAM and again after done.
//    -> first ignored; second restarts, done clears on the accepting edge, addr 0 reissued.

Source files
------------

// File: rtl/feature_mem_reader.sv
// Read-side sequencer for the 4-bank feature memory. It walks word addresses
// 0..NUM_WORDS-1 and buffers each 4-lane word in a small credit-managed FIFO.
// The FIFO then streams the words to the HD encoder over valid/ready.
module feature_mem_reader #(
    parameter int FEATURE_WIDTH = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int NUM_FEATURES  = 512,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_done,
    input  logic                     start,
    output logic [ADDR_WIDTH-1:0]    read_address,
    output logic                     re,
    input  logic [FEATURE_WIDTH-1:0] mem_out0,
    input  logic [FEATURE_WIDTH-1:0] mem_out1,
    input  logic [FEATURE_WIDTH-1:0] mem_out2,
    input  logic [FEATURE_WIDTH-1:0] mem_out3,
    output logic                     f_valid,
    input  logic                     f_ready,
    output logic [FEATURE_WIDTH-1:0] f0,
    output logic [FEATURE_WIDTH-1:0] f1,
    output logic [FEATURE_WIDTH-1:0] f2,
    output logic [FEATURE_WIDTH-1:0] f3,
    output logic [ADDR_WIDTH-1:0]    f_index,
    output logic                     f_last,
    output logic                     busy,
    output logic                     done
);

    localparam int NUM_WORDS = NUM_FEATURES / 4;
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;
    localparam int EW        = ADDR_WIDTH + 4 * FEATURE_WIDTH;

    localparam logic [ADDR_WIDTH:0]   NUM_WORDS_W = (ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [CW:0]           DEPTH_W     = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     issue_cnt_q, issue_cnt_d;
    logic [1:0]              inflight_q, inflight_d;
    logic                    pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [EW-1:0]           fifo_mem_q [FIFO_DEPTH];
    logic [EW-1:0]           fifo_mem_d [FIFO_DEPTH];

    logic          start_ok, abort, pop, push, clear;
    logic [EW-1:0] head;

    assign start_ok = start & write_done;
    assign abort    = (state_q == STREAM) & ~write_done;
    assign pop      = f_valid & f_ready;
    assign push     = pend_q;
    assign clear    = abort | ((state_q != STREAM) & start_ok);
    assign head     = fifo_mem_q[rd_ptr_q];

    // Next-state: start accepted from IDLE/DONE, abort on write_done loss, finish on last handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = STREAM;
            STREAM:  if (abort) state_d = IDLE;
                     else if (pop && f_last) state_d = DONE;
            DONE:    if (start_ok) state_d = STREAM;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: read issue gated by word budget and FIFO credit (entries + reads in flight)
    always_comb begin
        busy         = (state_q == STREAM);
        done         = (state_q == DONE);
        re           = (state_q == STREAM) && (issue_cnt_q < NUM_WORDS_W) &&
                       (({1'b0, count_q} + (CW + 1)'(inflight_q)) < DEPTH_W);
        read_address = (state_q == STREAM) ? issue_cnt_q[ADDR_WIDTH-1:0] : '0;
        f_valid      = (count_q != '0);
        f0           = f_valid ? head[0*FEATURE_WIDTH +: FEATURE_WIDTH] : '0;
        f1           = f_valid ? head[1*FEATURE_WIDTH +: FEATURE_WIDTH] : '0;
        f2           = f_valid ? head[2*FEATURE_WIDTH +: FEATURE_WIDTH] : '0;
        f3           = f_valid ? head[3*FEATURE_WIDTH +: FEATURE_WIDTH] : '0;
        f_index      = f_valid ? head[EW-1 -: ADDR_WIDTH] : '0;
        f_last       = f_valid && (head[EW-1 -: ADDR_WIDTH] == LAST_IDX);
    end

    // Datapath: issue counter, one-cycle read pipeline, FIFO push/pop; clear flushes stale reads
    always_comb begin
        issue_cnt_d = issue_cnt_q + (ADDR_WIDTH + 1)'(re);
        inflight_d  = inflight_q + 2'(re) - 2'(push);
        pend_d      = re;
        pend_addr_d = re ? read_address : pend_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        fifo_mem_d  = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {pend_addr_q, mem_out3, mem_out2, mem_out1, mem_out0};
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (clear) begin
            issue_cnt_d = '0;
            inflight_d  = '0;
            pend_d      = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end
    end

    // Control and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            inflight_q  <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are only visible through count_q so no reset is needed
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

endmodule

// File: tb/tb_feature_mem_reader.sv
// Directed testbench for feature_mem_reader with a registered-read memory model
// returning mem_outN = 4*addr+N.
module tb_feature_mem_reader;

    localparam int NW = 128;

    logic        clk = 1'b0;
    logic        reset, write_done, start, f_ready;
    logic [7:0]  read_address, f_index;
    logic        re, f_valid, f_last, busy, done;
    logic [31:0] mem_out0, mem_out1, mem_out2, mem_out3;
    logic [31:0] f0, f1, f2, f3;

    int errors = 0;
    int checks = 0;

    feature_mem_reader #(
        .FEATURE_WIDTH(32),
        .ADDR_WIDTH   (8),
        .NUM_FEATURES (512),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_done  (write_done),
        .start       (start),
        .read_address(read_address),
        .re          (re),
        .mem_out0    (mem_out0),
        .mem_out1    (mem_out1),
        .mem_out2    (mem_out2),
        .mem_out3    (mem_out3),
        .f_valid     (f_valid),
        .f_ready     (f_ready),
        .f0          (f0),
        .f1          (f1),
        .f2          (f2),
        .f3          (f3),
        .f_index     (f_index),
        .f_last      (f_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Registered-read feature memory
    always @(posedge clk) begin
        if (re) begin
            mem_out0 <= 32'(read_address) * 4 + 0;
            mem_out1 <= 32'(read_address) * 4 + 1;
            mem_out2 <= 32'(read_address) * 4 + 2;
            mem_out3 <= 32'(read_address) * 4 + 3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Accepts beats, checking order, content, stall stability and no-bubble behaviour.
    // mode 0: f_ready always 1; mode 1: 1010.. for 20 cycles, 0 for 20, then 1.
    // Stops (with f_ready low, beat stop_at not taken) when stop_at beats were accepted.
    task automatic consume(input int mode, input int stop_at);
        int k = 0;
        int c = 0;
        int bubbles = 0;
        bit seen = 0;
        bit held = 0;
        logic [31:0] s0, s1, s2, s3;
        logic [7:0]  sidx;
        logic        slast;
        logic [31:0] e0;
        while (k < NW && c < 3000) begin
            if (held) begin
                checks++;
                if (f_valid !== 1'b1 || f_index !== sidx || f0 !== s0 || f1 !== s1 ||
                    f2 !== s2 || f3 !== s3 || f_last !== slast) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b idx=%0d f0=%0d expected v=1 idx=%0d f0=%0d",
                             f_valid, f_index, f0, sidx, s0);
                end
            end
            if (k == stop_at) begin
                f_ready = 1'b0;
                return;
            end
            if (mode == 0) f_ready = 1'b1;
            else if (c < 20) f_ready = (c % 2 == 0);
            else if (c < 40) f_ready = 1'b0;
            else f_ready = 1'b1;
            if (mode == 1 && c == 35) begin
                checks++;
                if (re !== 1'b0) begin
                    errors++;
                    $display("FAIL credit_stop: got re=%0b expected re=0", re);
                end
            end
            held = 0;
            if (f_valid === 1'b1) begin
                seen = 1;
                if (f_ready) begin
                    e0 = 32'(k) * 4;
                    checks++;
                    if (f_index !== 8'(k) || f0 !== e0 || f1 !== e0 + 1 || f2 !== e0 + 2 ||
                        f3 !== e0 + 3 || f_last !== (k == NW - 1)) begin
                        errors++;
                        $display("FAIL beat%0d: got idx=%0d f=%0d,%0d,%0d,%0d last=%0b expected idx=%0d f=%0d,%0d,%0d,%0d last=%0b",
                                 k, f_index, f0, f1, f2, f3, f_last,
                                 k, e0, e0 + 1, e0 + 2, e0 + 3, (k == NW - 1));
                    end
                    k++;
                end else begin
                    held = 1;
                    s0 = f0; s1 = f1; s2 = f2; s3 = f3; sidx = f_index; slast = f_last;
                end
            end else if (seen) begin
                bubbles++;
            end
            tick();
            c++;
        end
        checks++;
        if (k != NW) begin
            errors++;
            $display("FAIL stream_timeout: got %0d beats expected %0d", k, NW);
        end else if (done !== 1'b1 || busy !== 1'b0 || f_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_after_last: got done=%0b busy=%0b v=%0b expected done=1 busy=0 v=0",
                     done, busy, f_valid);
        end
        if (mode == 0) begin
            checks++;
            if (bubbles != 0) begin
                errors++;
                $display("FAIL no_bubbles: got %0d bubbles expected 0", bubbles);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; write_done = 1'b0; start = 1'b0; f_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (re !== 0 || read_address !== 0 || f_valid !== 0 || f_last !== 0 || f_index !== 0 ||
            busy !== 0 || done !== 0 || f0 !== 0 || f1 !== 0 || f2 !== 0 || f3 !== 0) begin
            errors++;
            $display("FAIL reset_state: got re=%0b a=%0d v=%0b busy=%0b done=%0b f0=%0d expected all 0",
                     re, read_address, f_valid, busy, done, f0);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        write_done = 1'b1; f_ready = 1'b1;
        pulse_start();
        checks++;
        if (re !== 1'b1 || read_address !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_issue: got re=%0b a=%0d busy=%0b expected re=1 a=0 busy=1",
                     re, read_address, busy);
        end
        tick();
        checks++;
        if (f_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got v=%0b expected v=0", f_valid);
        end
        tick();
        checks++;
        if (f_valid !== 1'b1 || f0 !== 0 || f1 !== 1 || f2 !== 2 || f3 !== 3 || f_index !== 0) begin
            errors++;
            $display("FAIL first_beat: got v=%0b f=%0d,%0d,%0d,%0d idx=%0d expected v=1 f=0,1,2,3 idx=0",
                     f_valid, f0, f1, f2, f3, f_index);
        end
        consume(0, -1);
    endtask

    task automatic test_no_write_done();
        write_done = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (re !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_start_c%0d: got re=%0b busy=%0b expected re=0 busy=0", i, re, busy);
            end
            tick();
        end
        write_done = 1'b1;
        pulse_start();
        consume(0, -1);
    endtask

    task automatic test_backpressure();
        f_ready = 1'b0;
        pulse_start();
        consume(1, -1);
    endtask

    task automatic test_abort();
        f_ready = 1'b1;
        pulse_start();
        consume(0, 40);
        write_done = 1'b0;
        tick();
        checks++;
        if (busy !== 0 || f_valid !== 0 || done !== 0 || re !== 0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%0b v=%0b done=%0b re=%0b expected all 0",
                     busy, f_valid, done, re);
        end
        tick();
        checks++;
        if (f_valid !== 0) begin
            errors++;
            $display("FAIL abort_discard: got v=%0b expected v=0", f_valid);
        end
        write_done = 1'b1;
        pulse_start();
        consume(0, -1);
    endtask

    task automatic test_reset_mid_stream();
        f_ready = 1'b1;
        pulse_start();
        consume(0, 70);
        repeat (6) tick();
        checks++;
        if (f_valid !== 1'b1 || re !== 1'b0 || f_index !== 8'd70) begin
            errors++;
            $display("FAIL full_before_reset: got v=%0b re=%0b idx=%0d expected v=1 re=0 idx=70",
                     f_valid, re, f_index);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (re !== 0 || read_address !== 0 || f_valid !== 0 || f_last !== 0 || f_index !== 0 ||
            busy !== 0 || done !== 0 || f0 !== 0 || f1 !== 0 || f2 !== 0 || f3 !== 0) begin
            errors++;
            $display("FAIL reset_mid: got re=%0b a=%0d v=%0b idx=%0d busy=%0b f0=%0d expected all 0",
                     re, read_address, f_valid, f_index, busy, f0);
        end
        reset = 1'b0;
        tick();
        pulse_start();
        consume(0, -1);
    endtask

    task automatic test_restart();
        f_ready = 1'b0;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_stream: got busy=%0b done=%0b expected busy=1 done=0", busy, done);
        end
        consume(0, -1);
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || re !== 1'b1 || read_address !== 8'd0) begin
            errors++;
            $display("FAIL restart_from_done: got done=%0b busy=%0b re=%0b a=%0d expected done=0 busy=1 re=1 a=0",
                     done, busy, re, read_address);
        end
        consume(0, -1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_no_write_done();
        test_backpressure();
        test_abort();
        test_reset_mid_stream();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
